// File: rtl/downscale_job_ctrl.sv
// Job sequencer for the scalar bilinear downscale core: queues descriptors, validates, launches, counts.
// Latency: push into an empty queue -> pop next cycle -> CHECK one cycle -> LAUNCH; all outputs registered.
// Backpressure: job_ready drops while the 2-entry descriptor queue is full; the core is paced by STEP/ACK in stepping mode.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   job_valid/job_ready, job_*      descriptor push handshake and dimensions (Q8.8 inverse scale)
//   step_mode_cfg, step_req         stepping enable (latched at dequeue), one-cycle step request
//   core_start/_step_mode/_step     core control
//   core_in_*/core_out_*/core_inv_scale_q  core configuration, stable from CHECK until the next pop
//   core_step_ack/_busy/_done/_wr_valid    core status
//   ctl_busy, job_done, job_err, err_code  sequencer status and completion pulses
//   pix_count, cyc_count            statistics for the last job (saturating)
//   irq, irq_clr                    sticky interrupt and its clear
module downscale_job_ctrl #(
  parameter int W_MAX   = 64,
  parameter int H_MAX   = 64,
  parameter int TIMEOUT = 1048576
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [15:0] job_in_w,
  input  logic [15:0] job_in_h,
  input  logic [15:0] job_out_w,
  input  logic [15:0] job_out_h,
  input  logic [15:0] job_inv_scale_q,
  input  logic        step_mode_cfg,
  input  logic        step_req,
  output logic        core_start,
  output logic        core_step_mode,
  output logic        core_step,
  output logic [15:0] core_in_w,
  output logic [15:0] core_in_h,
  output logic [15:0] core_out_w,
  output logic [15:0] core_out_h,
  output logic [15:0] core_inv_scale_q,
  input  logic        core_step_ack,
  input  logic        core_busy,
  input  logic        core_done,
  input  logic        core_wr_valid,
  output logic        ctl_busy,
  output logic        job_done,
  output logic        job_err,
  output logic [1:0]  err_code,
  output logic [31:0] pix_count,
  output logic [31:0] cyc_count,
  output logic        irq,
  input  logic        irq_clr
);

  typedef struct packed {
    logic [15:0] in_w;
    logic [15:0] in_h;
    logic [15:0] out_w;
    logic [15:0] out_h;
    logic [15:0] inv_scale_q;
  } desc_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_LAUNCH = 3'd2,
    S_RUN    = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  localparam logic [31:0] W_LIM  = 32'(W_MAX);
  localparam logic [31:0] H_LIM  = 32'(H_MAX);
  localparam logic [31:0] TO_LIM = 32'(TIMEOUT);

  state_t      state, state_d;
  desc_t       q_mem [2];
  logic        q_rd, q_wr;
  logic [1:0]  q_cnt, q_cnt_d;
  logic        push, pop;
  desc_t       cfg, cfg_d, job_in;

  logic        step_mode_d, start_d, step_d, busy_d;
  logic        done_d, jerr_d, irq_d;
  logic [3:0]  pending, pend_d;
  logic [31:0] pix_d, cyc_d, pix_inc, cyc_inc, n_pix;
  logic [1:0]  err_d;
  logic        active, bad, timed_out, step_dec;

  assign job_in = '{in_w: job_in_w, in_h: job_in_h, out_w: job_out_w,
                    out_h: job_out_h, inv_scale_q: job_inv_scale_q};

  // Pop only from IDLE, so a fresh push is never bypassed straight into CHECK.
  assign push = job_valid && job_ready;
  assign pop  = (state == S_IDLE) && (q_cnt != 2'd0);

  always_comb begin
    q_cnt_d = q_cnt;
    if (push && !pop)      q_cnt_d = q_cnt + 2'd1;
    else if (!push && pop) q_cnt_d = q_cnt - 2'd1;
  end

  assign core_in_w        = cfg.in_w;
  assign core_in_h        = cfg.in_h;
  assign core_out_w       = cfg.out_w;
  assign core_out_h       = cfg.out_h;
  assign core_inv_scale_q = cfg.inv_scale_q;

  assign active    = (state == S_LAUNCH) || (state == S_RUN);
  assign cyc_inc   = (cyc_count == 32'hFFFF_FFFF) ? cyc_count : cyc_count + 32'd1;
  assign pix_inc   = (pix_count == 32'hFFFF_FFFF) ? pix_count : pix_count + 32'd1;
  assign n_pix     = {16'd0, cfg.out_w} * {16'd0, cfg.out_h};
  // Watchdog fires on the cycle whose increment reaches the limit, so cyc_count reads exactly TIMEOUT.
  assign timed_out = !core_step_mode && (cyc_inc >= TO_LIM);
  // A step completes on the cycle the ack is seen while our step is still high.
  assign step_dec  = core_step && core_step_ack;

  assign bad = (cfg.in_w == 16'd0) || (cfg.in_h == 16'd0) ||
               (cfg.out_w == 16'd0) || (cfg.out_h == 16'd0) ||
               ({16'd0, cfg.in_w} > W_LIM) || ({16'd0, cfg.in_h} > H_LIM) ||
               (cfg.out_w > cfg.in_w) || (cfg.out_h > cfg.in_h) ||
               (cfg.inv_scale_q == 16'd0);

  always_comb begin
    state_d     = state;
    cfg_d       = cfg;
    step_mode_d = core_step_mode;
    start_d     = 1'b0;
    step_d      = 1'b0;
    pend_d      = 4'd0;
    pix_d       = pix_count;
    cyc_d       = cyc_count;
    err_d       = err_code;
    done_d      = 1'b0;
    jerr_d      = 1'b0;
    // Pulses are registered, so a clear landing with a pulse loses to the set.
    irq_d       = job_done || job_err || (irq && !irq_clr);

    // Step engine runs only while the core is being driven in stepping mode.
    if (active && core_step_mode) begin
      case ({step_req, step_dec})
        2'b10:   pend_d = (pending == 4'hF) ? pending : pending + 4'd1;
        2'b01:   pend_d = pending - 4'd1;
        default: pend_d = pending;
      endcase
      if (step_dec)                               step_d = 1'b0;
      else if (core_step)                         step_d = 1'b1;
      else if (pending != 4'd0 && !core_step_ack) step_d = 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (pop) begin
          cfg_d       = q_mem[q_rd];
          step_mode_d = step_mode_cfg;
          pix_d       = 32'd0;
          cyc_d       = 32'd0;
          err_d       = 2'd0;
          state_d     = S_CHECK;
        end
      end
      S_CHECK: begin
        if (bad) begin
          err_d   = 2'd1;
          jerr_d  = 1'b1;
          state_d = S_FINISH;
        end else begin
          start_d = 1'b1;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH, S_RUN: begin
        cyc_d = cyc_inc;
        if (core_wr_valid) pix_d = pix_inc;
        if (state == S_RUN && core_done && !core_busy) begin
          state_d = S_FINISH;
          if (pix_d != n_pix) begin
            err_d  = 2'd3;
            jerr_d = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end else if (timed_out) begin
          err_d   = 2'd2;
          jerr_d  = 1'b1;
          state_d = S_FINISH;
        end else if (state == S_LAUNCH) begin
          if (core_busy) state_d = S_RUN;
          else           start_d = 1'b1;
        end
        if (state_d == S_FINISH) begin
          step_d = 1'b0;
          pend_d = 4'd0;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Queue storage needs no reset: entries are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (push) q_mem[q_wr] <= job_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      q_rd           <= 1'b0;
      q_wr           <= 1'b0;
      q_cnt          <= 2'd0;
      job_ready      <= 1'b1;
      cfg            <= '0;
      core_step_mode <= 1'b0;
      core_start     <= 1'b0;
      core_step      <= 1'b0;
      pending        <= 4'd0;
      pix_count      <= 32'd0;
      cyc_count      <= 32'd0;
      err_code       <= 2'd0;
      job_done       <= 1'b0;
      job_err        <= 1'b0;
      irq            <= 1'b0;
      ctl_busy       <= 1'b0;
    end else begin
      state          <= state_d;
      if (push) q_wr <= ~q_wr;
      if (pop)  q_rd <= ~q_rd;
      q_cnt          <= q_cnt_d;
      job_ready      <= (q_cnt_d != 2'd2);
      cfg            <= cfg_d;
      core_step_mode <= step_mode_d;
      core_start     <= start_d;
      core_step      <= step_d;
      pending        <= pend_d;
      pix_count      <= pix_d;
      cyc_count      <= cyc_d;
      err_code       <= err_d;
      job_done       <= done_d;
      job_err        <= jerr_d;
      irq            <= irq_d;
      ctl_busy       <= busy_d;
    end
  end

endmodule
